// File: rtl/matrix_mul_host_mailbox.sv
// Host-side mailbox initiator for the accelerator control BRAM: writes the job
// descriptor and start word, polls word0 until busy clears, then reports status.
module matrix_mul_host_mailbox #(
  parameter int POLL_GAP       = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [15:0]      job_m,
  input  logic [15:0]      job_n,
  input  logic [15:0]      job_k,
  output logic             done_valid,
  output logic [7:0]       done_status,
  output logic             done_timeout,
  output logic             done_reject,
  output logic [CNT_W-1:0] done_cycles,
  output logic [8:0]       bram_addr,
  output logic [63:0]      bram_din,
  input  logic [63:0]      bram_dout,
  output logic             bram_en,
  output logic             bram_we
);

  typedef enum logic [3:0] {
    IDLE, WR_D1, WR_D2, WR_GO, RD_ISSUE, RD_WAIT, CHECK, GAP, DONE
  } state_t;

  localparam logic [31:0] GAP_INIT = (POLL_GAP > 0) ? 32'(POLL_GAP - 1) : 32'd0;
  localparam logic [63:0] TO_LIM   = 64'(TIMEOUT_CYCLES);

  state_t           state, state_nxt;
  logic [15:0]      m_q, n_q, k_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      gap_cnt;

  logic             fin, fin_reject, fin_timeout;
  logic [7:0]       fin_status;
  logic [CNT_W-1:0] fin_cycles;
  logic             dim_zero;
  logic [63:0]      desc;

  logic             en_nxt, we_nxt;
  logic [8:0]       addr_nxt;
  logic [63:0]      din_nxt;
  logic             dout_unused;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign job_ready   = (state == IDLE);
  assign dim_zero    = (job_m == 16'd0) || (job_n == 16'd0) || (job_k == 16'd0);
  // In IDLE the dimensions are not latched yet, so the first write takes them from the inputs.
  assign desc        = (state == IDLE) ? {16'd0, job_m, job_n, job_k} : {16'd0, m_q, n_q, k_q};
  assign dout_unused = ^{bram_dout[63:16], bram_dout[7:1]};

  always_comb begin
    state_nxt   = state;
    fin         = 1'b0;
    fin_reject  = 1'b0;
    fin_timeout = 1'b0;
    fin_status  = 8'd0;
    fin_cycles  = '0;
    case (state)
      IDLE: begin
        if (job_valid) begin
          if (dim_zero) begin
            state_nxt  = DONE;
            fin        = 1'b1;
            fin_reject = 1'b1;
          end else begin
            state_nxt = WR_D1;
          end
        end
      end
      WR_D1:    state_nxt = WR_D2;
      WR_D2:    state_nxt = WR_GO;
      WR_GO:    state_nxt = RD_ISSUE;
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = CHECK;
      CHECK: begin
        if (!bram_dout[0]) begin
          state_nxt  = DONE;
          fin        = 1'b1;
          fin_status = bram_dout[15:8];
          fin_cycles = cnt;
        end else if ((TIMEOUT_CYCLES != 0) && (64'(cnt) >= TO_LIM)) begin
          state_nxt   = DONE;
          fin         = 1'b1;
          fin_timeout = 1'b1;
          fin_cycles  = cnt;
        end else if (POLL_GAP == 0) begin
          state_nxt = RD_ISSUE;
        end else begin
          state_nxt = GAP;
        end
      end
      GAP:     if (gap_cnt == 32'd0) state_nxt = RD_ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // BRAM controls are registered from the next state so the port sees clean levels.
  always_comb begin
    en_nxt   = 1'b0;
    we_nxt   = 1'b0;
    addr_nxt = 9'd0;
    din_nxt  = 64'd0;
    case (state_nxt)
      WR_D1: begin
        en_nxt   = 1'b1;
        we_nxt   = 1'b1;
        addr_nxt = 9'd1;
        din_nxt  = desc;
      end
      WR_D2: begin
        en_nxt   = 1'b1;
        we_nxt   = 1'b1;
        addr_nxt = 9'd2;
        din_nxt  = desc;
      end
      WR_GO: begin
        en_nxt  = 1'b1;
        we_nxt  = 1'b1;
        din_nxt = 64'd1;
      end
      RD_ISSUE: en_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      m_q          <= 16'd0;
      n_q          <= 16'd0;
      k_q          <= 16'd0;
      cnt          <= '0;
      gap_cnt      <= 32'd0;
      done_valid   <= 1'b0;
      done_status  <= 8'd0;
      done_timeout <= 1'b0;
      done_reject  <= 1'b0;
      done_cycles  <= '0;
      bram_en      <= 1'b0;
      bram_we      <= 1'b0;
      bram_addr    <= 9'd0;
      bram_din     <= 64'd0;
    end else begin
      state      <= state_nxt;
      done_valid <= fin;
      bram_en    <= en_nxt;
      bram_we    <= we_nxt;
      bram_addr  <= addr_nxt;
      bram_din   <= din_nxt;
      if (state == IDLE && job_valid) begin
        m_q <= job_m;
        n_q <= job_n;
        k_q <= job_k;
      end
      if (state == WR_GO) begin
        cnt <= '0;
      end else if (state == RD_ISSUE || state == RD_WAIT || state == CHECK || state == GAP) begin
        cnt <= sat_inc(cnt);
      end
      if (state == CHECK) begin
        gap_cnt <= GAP_INIT;
      end else if (state == GAP && gap_cnt != 32'd0) begin
        gap_cnt <= gap_cnt - 32'd1;
      end
      if (fin) begin
        done_status  <= fin_status;
        done_timeout <= fin_timeout;
        done_reject  <= fin_reject;
        done_cycles  <= fin_cycles;
      end
    end
  end

endmodule
